// File: rtl/ravenoc_axi_master_pkg.sv
// Shared AXI4 types, widths and helpers for the RaveNoC AXI master.
package ravenoc_axi_master_pkg;

  localparam int AXI_ADDR_WIDTH      = 32;
  localparam int AXI_DATA_WIDTH      = 32;
  localparam int AXI_ALEN_WIDTH      = 8;
  localparam int AXI_ID_WIDTH        = 4;
  localparam int AXI_USER_WIDTH      = 1;
  localparam int AXI_SIZE_BYTES_LOG2 = $clog2(AXI_DATA_WIDTH / 8);

  typedef logic [AXI_ADDR_WIDTH-1:0]   axi_addr_t;
  typedef logic [AXI_DATA_WIDTH-1:0]   axi_data_t;
  typedef logic [AXI_ALEN_WIDTH-1:0]   axi_len_t;
  typedef logic [AXI_ID_WIDTH-1:0]     axi_id_t;
  typedef logic [AXI_USER_WIDTH-1:0]   axi_user_t;
  // One extra bit so a 256-beat burst can be counted without wrapping.
  typedef logic [AXI_ALEN_WIDTH:0]     beat_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } aerror_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } aburst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } m_axi_st_t;

  typedef struct packed {
    axi_id_t                     awid;
    axi_addr_t                   awaddr;
    axi_len_t                    awlen;
    logic [2:0]                  awsize;
    aburst_t                     awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awqos;
    logic [3:0]                  awregion;
    axi_user_t                   awuser;
    logic                        awvalid;
    axi_data_t                   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    axi_user_t                   wuser;
    logic                        wvalid;
    logic                        bready;
    axi_id_t                     arid;
    axi_addr_t                   araddr;
    axi_len_t                    arlen;
    logic [2:0]                  arsize;
    aburst_t                     arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic [3:0]                  arregion;
    axi_user_t                   aruser;
    logic                        arvalid;
    logic                        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_id_t   bid;
    aerror_t   bresp;
    axi_user_t buser;
    logic      bvalid;
    logic      arready;
    axi_id_t   rid;
    axi_data_t rdata;
    aerror_t   rresp;
    logic      rlast;
    axi_user_t ruser;
    logic      rvalid;
  } s_axi_miso_t;

  // Severity ranking DECERR > SLVERR > EXOKAY > OKAY follows the encoding.
  function automatic aerror_t worst_resp(aerror_t a, aerror_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ravenoc_axi_master_wdog.sv
// Handshake watchdog: counts enabled idle cycles, flags expiry at the limit.
module ravenoc_axi_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit ACTIVE = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] cnt_reg;

  // Counter: clear has priority, then count while enabled (never when disabled).
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en && ACTIVE) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Expiry is taken from the registered count only, so it never depends on clr.
  assign expire = ACTIVE && en && (cnt_reg == LIMIT);

endmodule

// File: rtl/ravenoc_axi_master.sv
// AXI4 initiator turning command/stream requests into single INCR bursts.
module ravenoc_axi_master
  import ravenoc_axi_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk_axi,
  input  logic                      rst_axi,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  axi_addr_t                 cmd_addr,
  input  logic [AXI_ALEN_WIDTH-1:0] cmd_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_last,
  output logic                      rsp_valid,
  output aerror_t                   rsp_err,
  output logic                      rsp_proto,
  output logic                      rsp_timeout,
  output s_axi_mosi_t               axi_mosi_o,
  input  s_axi_miso_t               axi_miso_i
);

  m_axi_st_t state_reg, state_next;
  beat_t     beat_reg, beat_next;
  aerror_t   err_reg, err_next;
  logic      proto_reg, proto_next;
  logic      tout_reg, tout_next;
  axi_addr_t addr_reg, addr_next;
  axi_len_t  len_reg, len_next;

  logic last_beat;
  logic any_hs;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;
  logic unused_bits;

  assign last_beat = (beat_reg == {1'b0, len_reg});
  assign unused_bits = ^{axi_miso_i.bid, axi_miso_i.buser, axi_miso_i.rid, axi_miso_i.ruser};

  // State and burst bookkeeping registers.
  always_ff @(posedge clk_axi) begin
    if (rst_axi) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      err_reg   <= OKAY;
      proto_reg <= 1'b0;
      tout_reg  <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      err_reg   <= err_next;
      proto_reg <= proto_next;
      tout_reg  <= tout_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
    end
  end

  // Next-state and output decode; everything handshake-related is forced low in reset.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    err_next   = err_reg;
    proto_next = proto_reg;
    tout_next  = tout_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;

    axi_mosi_o         = '0;
    axi_mosi_o.awid    = AXI_ID_WIDTH'(AXI_ID);
    axi_mosi_o.awaddr  = addr_reg;
    axi_mosi_o.awlen   = len_reg;
    axi_mosi_o.awsize  = 3'(AXI_SIZE_BYTES_LOG2);
    axi_mosi_o.awburst = INCR;
    axi_mosi_o.arid    = AXI_ID_WIDTH'(AXI_ID);
    axi_mosi_o.araddr  = addr_reg;
    axi_mosi_o.arlen   = len_reg;
    axi_mosi_o.arsize  = 3'(AXI_SIZE_BYTES_LOG2);
    axi_mosi_o.arburst = INCR;
    axi_mosi_o.wstrb   = '1;
    axi_mosi_o.wdata   = wr_data;

    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = axi_miso_i.rdata;
    rd_last     = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = OKAY;
    rsp_proto   = 1'b0;
    rsp_timeout = 1'b0;

    if (!rst_axi) begin
      case (state_reg)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_next  = cmd_addr;
            len_next   = cmd_len;
            state_next = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
          end
        end
        ST_WR_ADDR: begin
          axi_mosi_o.awvalid = 1'b1;
          if (axi_miso_i.awready) state_next = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          axi_mosi_o.wvalid = wr_valid;
          axi_mosi_o.wlast  = last_beat;
          wr_ready          = axi_miso_i.wready;
          if (wr_valid && axi_miso_i.wready) begin
            beat_next = beat_reg + beat_t'(1);
            if (last_beat) state_next = ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          axi_mosi_o.bready = 1'b1;
          if (axi_miso_i.bvalid) begin
            err_next   = axi_miso_i.bresp;
            state_next = ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          axi_mosi_o.arvalid = 1'b1;
          if (axi_miso_i.arready) state_next = ST_RD_DATA;
        end
        ST_RD_DATA: begin
          rd_valid          = axi_miso_i.rvalid;
          rd_last           = last_beat;
          axi_mosi_o.rready = rd_ready;
          if (axi_miso_i.rvalid && rd_ready) begin
            err_next  = worst_resp(err_reg, axi_miso_i.rresp);
            if (axi_miso_i.rlast != last_beat) proto_next = 1'b1;
            beat_next = beat_reg + beat_t'(1);
            if (last_beat) state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_valid   = 1'b1;
          rsp_err     = err_reg;
          rsp_proto   = proto_reg;
          rsp_timeout = tout_reg;
          beat_next   = '0;
          err_next    = OKAY;
          proto_next  = 1'b0;
          tout_next   = 1'b0;
          state_next  = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase

      // Watchdog abort: withdraw every valid/ready so nothing completes this cycle.
      if (wd_expire) begin
        axi_mosi_o.awvalid = 1'b0;
        axi_mosi_o.wvalid  = 1'b0;
        axi_mosi_o.wlast   = 1'b0;
        axi_mosi_o.bready  = 1'b0;
        axi_mosi_o.arvalid = 1'b0;
        axi_mosi_o.rready  = 1'b0;
        wr_ready           = 1'b0;
        rd_valid           = 1'b0;
        rd_last            = 1'b0;
        beat_next          = beat_reg;
        err_next           = err_reg;
        proto_next         = proto_reg;
        tout_next          = 1'b1;
        state_next         = ST_DONE;
      end
    end
  end

  assign any_hs = (axi_mosi_o.awvalid && axi_miso_i.awready) ||
                  (axi_mosi_o.wvalid  && axi_miso_i.wready)  ||
                  (axi_mosi_o.bready  && axi_miso_i.bvalid)  ||
                  (axi_mosi_o.arvalid && axi_miso_i.arready) ||
                  (axi_mosi_o.rready  && axi_miso_i.rvalid);
  assign wd_clr = any_hs || (state_next != state_reg);
  assign wd_en  = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

  ravenoc_axi_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk_axi),
    .srst   (rst_axi),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

endmodule

// File: tb/tb_ravenoc_axi_master.sv
// Directed bench for ravenoc_axi_master; the test slave is driven inline.
module tb_ravenoc_axi_master;
  import ravenoc_axi_master_pkg::*;

  logic        clk_axi = 1'b0;
  logic        rst_axi = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  axi_addr_t   cmd_addr = '0;
  logic [AXI_ALEN_WIDTH-1:0] cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [AXI_DATA_WIDTH-1:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [AXI_DATA_WIDTH-1:0] rd_data;
  logic        rd_last;
  logic        rsp_valid;
  aerror_t     rsp_err;
  logic        rsp_proto;
  logic        rsp_timeout;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  int tests = 0;
  int fails = 0;

  ravenoc_axi_master #(
    .TIMEOUT_CYCLES (16),
    .AXI_ID         (0)
  ) dut (
    .clk_axi     (clk_axi),
    .rst_axi     (rst_axi),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_proto   (rsp_proto),
    .rsp_timeout (rsp_timeout),
    .axi_mosi_o  (axi_mosi),
    .axi_miso_i  (axi_miso)
  );

  always #5 clk_axi = ~clk_axi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_axi);
  endtask

  task automatic issue(input logic wr, input axi_addr_t addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    sample();
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, sent, lasts, last_pos, bad, stall, seen;
    logic done;
    axi_miso = '0;

    // Reset state
    repeat (3) tick();
    sample();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", axi_mosi.awvalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awsize", axi_mosi.awsize, 2);
    tick();
    rst_axi = 1'b0;
    sample();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    $display("[TB] reset checked");

    // Write len 3 at 0x1000, slave always ready
    tick();
    issue(1'b1, 32'h1000, 8'd3);
    axi_miso.awready = 1'b1;
    sample();
    chk("wr_awvalid", axi_mosi.awvalid, 1);
    chk("wr_awaddr", axi_mosi.awaddr, 32'h1000);
    chk("wr_awlen", axi_mosi.awlen, 3);
    chk("wr_awburst", axi_mosi.awburst, 1);
    chk("wr_wstrb", axi_mosi.wstrb, 4'hF);
    tick();
    axi_miso.awready = 1'b0;
    axi_miso.wready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA + 32'(i);
      sample();
      chk("wr_wvalid", axi_mosi.wvalid, 1);
      chk("wr_wdata", axi_mosi.wdata, 32'hA + 32'(i));
      chk("wr_wlast", axi_mosi.wlast, (i == 3) ? 1 : 0);
      tick();
    end
    wr_valid = 1'b0;
    axi_miso.wready = 1'b0;
    axi_miso.bvalid = 1'b1;
    axi_miso.bresp  = OKAY;
    sample();
    chk("wr_bready", axi_mosi.bready, 1);
    chk("wr_wr_ready_off", wr_ready, 0);
    tick();
    axi_miso.bvalid = 1'b0;
    sample();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, OKAY);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    tick();
    sample();
    chk("wr_rsp_one_cycle", rsp_valid, 0);
    chk("wr_back_idle", cmd_ready, 1);
    $display("[TB] write len=3 done");

    // Read len 0 at 0x2000 with rd_ready held off for 5 cycles
    tick();
    issue(1'b0, 32'h2000, 8'd0);
    axi_miso.arready = 1'b1;
    sample();
    chk("rd_arvalid", axi_mosi.arvalid, 1);
    chk("rd_araddr", axi_mosi.araddr, 32'h2000);
    chk("rd_arlen", axi_mosi.arlen, 0);
    tick();
    axi_miso.arready = 1'b0;
    axi_miso.rvalid  = 1'b1;
    axi_miso.rdata   = 32'hCAFE;
    axi_miso.rlast   = 1'b1;
    axi_miso.rresp   = OKAY;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("rd_rready_held", axi_mosi.rready, 0);
      chk("rd_valid_held", rd_valid, 1);
      tick();
    end
    rd_ready = 1'b1;
    sample();
    chk("rd_rready", axi_mosi.rready, 1);
    chk("rd_data", rd_data, 32'hCAFE);
    chk("rd_last", rd_last, 1);
    tick();
    axi_miso.rvalid = 1'b0;
    rd_ready = 1'b0;
    sample();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_err", rsp_err, OKAY);
    chk("rd_rsp_proto", rsp_proto, 0);
    chk("rd_rsp_timeout", rsp_timeout, 0);
    $display("[TB] read len=0 done");

    // Read len 2: rlast early on beat 1, SLVERR on beat 2
    tick();
    issue(1'b0, 32'h3000, 8'd2);
    axi_miso.arready = 1'b1;
    sample();
    tick();
    axi_miso.arready = 1'b0;
    rd_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      axi_miso.rvalid = 1'b1;
      axi_miso.rdata  = 32'h100 + 32'(i);
      axi_miso.rlast  = (i == 1);
      if (i == 2) axi_miso.rresp = SLVERR;
      else        axi_miso.rresp = OKAY;
      sample();
      if (axi_mosi.rready) n++;
      chk("rd3_rd_last", rd_last, (i == 2) ? 1 : 0);
      tick();
    end
    chk("rd3_beats", n, 3);
    // Slave keeps offering a fourth beat; it must not be taken.
    axi_miso.rlast = 1'b1;
    axi_miso.rresp = OKAY;
    sample();
    chk("rd3_rsp_valid", rsp_valid, 1);
    chk("rd3_rsp_proto", rsp_proto, 1);
    chk("rd3_rsp_err", rsp_err, SLVERR);
    chk("rd3_extra_rready", axi_mosi.rready, 0);
    tick();
    axi_miso.rvalid = 1'b0;
    rd_ready = 1'b0;
    $display("[TB] read len=2 proto/slverr done");

    // Watchdog: awready never comes. Counter 0..14 with awvalid high,
    // on the 16th cycle (count 15) valids drop, then DONE, then IDLE.
    issue(1'b1, 32'h4000, 8'd0);
    axi_miso.awready = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (!axi_mosi.awvalid) break;
      n++;
      tick();
    end
    chk("tout_aw_cycles", n, 15);
    chk("tout_no_rsp_yet", rsp_valid, 0);
    tick();
    sample();
    chk("tout_rsp_valid", rsp_valid, 1);
    chk("tout_rsp_timeout", rsp_timeout, 1);
    chk("tout_awvalid_low", axi_mosi.awvalid, 0);
    tick();
    sample();
    chk("tout_cmd_ready", cmd_ready, 1);
    $display("[TB] watchdog timeout done");

    // 256-beat write with random gaps on both sides
    tick();
    issue(1'b1, 32'h8000, 8'd255);
    axi_miso.awready = 1'b1;
    sample();
    tick();
    axi_miso.awready = 1'b0;
    sent = 0; lasts = 0; last_pos = -1; bad = 0; stall = 0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (stall >= 3) begin
        wr_valid = 1'b1;
        axi_miso.wready = 1'b1;
      end else begin
        wr_valid = ($urandom_range(0, 3) != 0);
        axi_miso.wready = ($urandom_range(0, 3) != 0);
      end
      wr_data = 32'h5A00_0000 + 32'(sent);
      sample();
      if (axi_mosi.bready) begin
        done = 1'b1;
      end else begin
        if (axi_mosi.wvalid && axi_miso.wready) begin
          if (axi_mosi.wdata !== 32'h5A00_0000 + 32'(sent)) bad++;
          if (axi_mosi.wlast) begin
            lasts++;
            last_pos = sent;
          end
          sent++;
          stall = 0;
        end else begin
          stall++;
        end
        tick();
      end
    end
    chk("long_reached_resp", done, 1);
    chk("long_beats", sent, 256);
    chk("long_wlast_count", lasts, 1);
    chk("long_wlast_pos", last_pos, 255);
    chk("long_data_order", bad, 0);
    wr_valid = 1'b0;
    axi_miso.wready = 1'b0;
    axi_miso.bvalid = 1'b1;
    axi_miso.bresp  = OKAY;
    tick();
    axi_miso.bvalid = 1'b0;
    sample();
    chk("long_rsp_valid", rsp_valid, 1);
    chk("long_rsp_err", rsp_err, OKAY);
    tick();
    $display("[TB] write len=255 done");

    // Reset during beat 2 of a 4-beat write
    issue(1'b1, 32'h9000, 8'd3);
    axi_miso.awready = 1'b1;
    sample();
    tick();
    axi_miso.awready = 1'b0;
    axi_miso.wready  = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 32'h20 + 32'(i);
      sample();
      tick();
    end
    rst_axi = 1'b1;
    axi_miso.bvalid = 1'b1;
    sample();
    chk("mid_rst_wvalid", axi_mosi.wvalid, 0);
    tick();
    rst_axi  = 1'b0;
    wr_valid = 1'b0;
    sample();
    chk("mid_rst_awvalid", axi_mosi.awvalid, 0);
    chk("mid_rst_wvalid_after", axi_mosi.wvalid, 0);
    chk("mid_rst_bready", axi_mosi.bready, 0);
    chk("mid_rst_idle", cmd_ready, 1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (rsp_valid) seen++;
      tick();
    end
    chk("mid_rst_no_rsp", seen, 0);
    axi_miso.bvalid = 1'b0;

    // Recovery: a single-beat write must mark its first beat last (counter cleared).
    issue(1'b1, 32'hA000, 8'd0);
    axi_miso.awready = 1'b1;
    sample();
    tick();
    axi_miso.awready = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 32'h77;
    sample();
    chk("recover_wlast", axi_mosi.wlast, 1);
    tick();
    wr_valid = 1'b0;
    axi_miso.wready = 1'b0;
    axi_miso.bvalid = 1'b1;
    axi_miso.bresp  = DECERR;
    tick();
    axi_miso.bvalid = 1'b0;
    sample();
    chk("recover_rsp_err", rsp_err, DECERR);
    $display("[TB] mid-burst reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ravenoc_axi_master.md
Name: ravenoc_axi_master

Overview:
- AXI4 initiator that drives one RaveNoC NI slave port (s_axi_mosi_t / s_axi_miso_t).
- Converts simple command/stream requests into AXI INCR write bursts (packet injection) and read bursts (packet extraction).
- Used as a per-tile traffic source/sink and as the bench-side driver for the NoC's AXI slave ports.
- One outstanding transaction; no AW/W overlap.

Parameters:
- TIMEOUT_CYCLES, 1024: idle-handshake watchdog limit; 0 disables it.
- AXI_ID, 0: constant value driven on awid/arid.

Ports:
- clk_axi  in  1  block clock; one clock, all logic on rising edge.
- rst_axi  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  axi_addr_t  burst start address.
- cmd_len  in  AXI_ALEN_WIDTH  beats-1.
- wr_valid  in  1  write-data stream valid.
- wr_ready  out  1  write-data stream ready.
- wr_data  in  AXI_DATA_WIDTH  write beat.
- rd_valid  out  1  read-data stream valid.
- rd_ready  in  1  read-data stream ready.
- rd_data  out  AXI_DATA_WIDTH  read beat.
- rd_last  out  1  last read beat.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  aerror_t  BRESP/RRESP worst-case.
- rsp_proto  out  1  RLAST mismatch flag.
- rsp_timeout  out  1  watchdog abort flag.
- axi_mosi_o  out  s_axi_mosi_t  AXI request bundle.
- axi_miso_i  in  s_axi_miso_t  AXI response bundle.

Behaviour:
- Reset: state=IDLE, beat_cnt=0, wd_cnt=0, err=OKAY. All AXI valids/readies, rd_valid, rsp_* and cmd_ready are 0 during reset; cmd_ready rises the first cycle after reset.
- Static AXI fields:
  - awsize/arsize = log2(AXI_DATA_WIDTH/8); burst=INCR.
  - wstrb all ones; id=AXI_ID.
  - lock/cache/prot/qos/region/user = 0.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: on cmd_valid&cmd_ready, latch addr/len/write; go to WR_ADDR or RD_ADDR next cycle.
- WR_ADDR: awvalid=1 with awaddr/awlen latched and stable until awready; then WR_DATA.
- WR_DATA:
  - wvalid=wr_valid, wdata=wr_data, wr_ready=wready; wr_ready=0 in every other state.
  - beat_cnt increments per wvalid&wready; wlast=(beat_cnt==len).
  - The last beat's handshake moves to WR_RESP.
- WR_RESP: bready=1; on bvalid, err=bresp; go to DONE.
- RD_ADDR: arvalid=1 until arready; then RD_DATA.
- RD_DATA:
  - rd_valid=rvalid, rd_data=rdata, rd_last=(beat_cnt==len), rready=rd_ready (combinational pass-through).
  - Per beat: err=max(err, rresp); beat_cnt++.
  - proto_err sets if rlast != (beat_cnt==len).
  - Exit to DONE on the handshake of the beat where beat_cnt==len; extra beats are not accepted.
- DONE: rsp_valid=1 for exactly one cycle with rsp_err/rsp_proto/rsp_timeout; clear beat_cnt/err/flags; go to IDLE. cmd_ready stays 0 in DONE.
- Watchdog:
  - wd_cnt clears on any AXI handshake or state change; otherwise increments in every non-IDLE, non-DONE state.
  - At wd_cnt==TIMEOUT_CYCLES-1: drop all valids, set rsp_timeout, go to DONE.
  - Stalls caused by the user (wr_valid=0 or rd_ready=0) also count.
- Width rules: beat_cnt is AXI_ALEN_WIDTH+1 bits; cmd_len=max (255) gives 256 beats with no wrap.
- Simultaneous events: awready arriving the same cycle awvalid rises is a valid handshake. B or R arriving early (before W completes / in the wrong state) is ignored.
- Reset mid-burst: abort immediately to IDLE with all outputs at reset values. No rsp_valid is issued for the aborted command.

Decomposition:
- ravenoc_pkg additions:
  - enum m_axi_st_t (FSM states).
  - function worst_resp(aerror_t, aerror_t): DECERR > SLVERR > EXOKAY > OKAY.
  - localparam AXI_SIZE_BYTES_LOG2.
- One sub-module, ravenoc_axi_wdog: counter with clear, enable and expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write, cmd_len=3, addr 0x1000, data 0xA..0xD, slave always ready -> AW then 4 W beats, wlast only on 0xD, bresp OKAY -> rsp_valid 1 cycle, rsp_err=OKAY.
- Read, cmd_len=0, addr 0x2000, slave returns 0xCAFE with rlast=1, rd_ready held 0 for 5 cycles -> rready low until rd_ready, rd_last=1, rsp_err=OKAY.
- Read, cmd_len=2; slave asserts rlast on beat 1 and RRESP=SLVERR on beat 2 -> 3 beats accepted, rsp_proto=1, rsp_err=SLVERR.
- TIMEOUT_CYCLES=16, awready never asserted -> awvalid drops after 16 cycles, rsp_timeout=1, cmd_ready back high 2 cycles later.
- cmd_len=255 write with random wr_valid/wready gaps -> exactly 256 beats, wlast only on beat 256, data order preserved.
- rst_axi pulsed during WR_DATA beat 2 of 4 -> next cycle all valids 0, state IDLE, no rsp_valid.
